pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the system PLL from the free-running 50 MHz reference domain: drives the PLL reset,
//  waits for lock with a timeout and retry, and debounces lock. It holds the core reset until
//  lock has been stable, then releases it. It re-sequences on lock loss or on a soft request.
//  Sits directly upstream of the PLL: pll_rst feeds its reset; its locked output returns here.
//  sys_rst is in the reference domain; consumers re-synchronise it into their own clocks.
// PARAMETERS
//  RST_CYCLES     16         cycles pll_rst is held after leaving reset/entering PLL_RST (>=1)
//  LOCK_TIMEOUT   1000000    WAIT_LOCK cycles without lock before retry (20 ms @ 50 MHz, >=1)
//  STABLE_CYCLES  4096       consecutive synced-lock cycles required before release (>=1)
//  CNT_W          8          width of the saturating retry/loss counters
// PORTS
//  clk        in   1      50 MHz free-running reference clock
//  rst        in   1      synchronous, active-high reset
//  pll_locked in   1      PLL lock, asynchronous to clk
//  soft_req   in   1      1-cycle pulse: request full re-sequence
//  pll_rst    out  1      reset to the PLL
//  sys_rst    out  1      core reset, active-high
//  ready      out  1      high only in RUN (== ~sys_rst)
//  retry_cnt  out  CNT_W  lock-timeout retries, saturates at all-ones
//  lost_cnt   out  CNT_W  lock losses while in RUN, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=1): state=PLL_RST, cnt=0, sync flops=0, pll_rst=1, sys_rst=1, ready=0,
//    retry_cnt=0, lost_cnt=0. rst overrides every other input.
//  - pll_locked passes through a 2-flop synchroniser; locked_s lags the pin by 2 edges.
//  - All outputs are registered and change on the edge that performs the state change.
//  - PLL_RST: pll_rst=1, sys_rst=1. Holds RST_CYCLES edges after entry (or after rst falls),
//    then goes to WAIT_LOCK with cnt=0. soft_req here restarts the count.
//  - WAIT_LOCK: pll_rst=0, sys_rst=1.
//      - locked_s=1 -> STABLE with cnt=0.
//      - Else, on the LOCK_TIMEOUT-th cycle -> PLL_RST; retry_cnt+1 (saturating).
//  - STABLE: pll_rst=0, sys_rst=1.
//      - locked_s=0 -> WAIT_LOCK; timeout count restarts; no counter change.
//      - Otherwise cnt++; at the edge where cnt==STABLE_CYCLES-1 -> RUN, sys_rst<=0, ready<=1.
//  - Release latency: sys_rst is low after edge E+2+STABLE_CYCLES, where E is the first edge
//    sampling pll_locked=1 in WAIT_LOCK, provided lock stays high throughout.
//  - RUN: pll_rst=0, sys_rst=0.
//      - locked_s=0 -> PLL_RST; same edge sys_rst<=1, pll_rst<=1, ready<=0, lost_cnt+1 (sat).
//  - soft_req in WAIT_LOCK/STABLE/RUN -> PLL_RST with cnt=0; no counter increment.
//      - soft_req together with lock loss in RUN: go to PLL_RST and lost_cnt increments.
//  - A soft_req or rst arriving mid-STABLE discards all debounce progress.
//  - Counter width: internal cnt is $clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1.
//    It never wraps; it is cleared on every state entry.
// TESTING  (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, CNT_W=8)
//  1. Release rst, raise locked 10 cycles later and hold -> pll_rst high exactly 4 cycles
//     after rst falls; sys_rst low exactly 10 edges after first sampled lock; ready=1.
//  2. locked held 0 -> pll_rst re-pulses every 104 cycles; retry_cnt 1,2,3...
//     Force 300 timeouts -> retry_cnt saturates at 255.
//  3. Lock high 5 cycles, glitch low 1 cycle, then high -> sys_rst stays high.
//     Release is 10 edges after the re-lock sample; lost_cnt=0.
//  4. In RUN, drop locked -> 2 edges later sys_rst=1, pll_rst=1, lost_cnt=1.
//     Full sequence then repeats on re-lock.
//  5. In RUN, pulse soft_req -> PLL_RST next edge, counters unchanged.
//     soft_req at the same edge as synced lock loss -> lost_cnt+1.
//  6. Assert rst mid-STABLE and mid-RUN -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Runs the system PLL start-up sequence from the free-running reference clock.
// It pulses the PLL reset, waits for lock (with timeout and retry), debounces
// the lock, and then releases the core reset. Lock loss or a soft request
// starts the whole sequence again.
// All outputs are registered. Each output changes on the clock edge that
// performs the matching state change.

module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 1000000,
   parameter int STABLE_CYCLES = 4096,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             soft_req,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic [CNT_W-1:0] retry_cnt,
   output logic [CNT_W-1:0] lost_cnt
);

   // The shared phase counter must be wide enough to hold the largest terminal count.
   localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_V = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CW    = $clog2(MAX_V + 1);

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_PLL_RST   = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_STABLE    = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nx;
   logic            sync_meta;
   logic            locked_s;
   logic            retry_inc;
   logic            lost_inc;
   logic            pll_rst_nx;
   logic            sys_rst_nx;
   logic            ready_nx;

   // Increment that stops at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] one;
      one = {{(CNT_W-1){1'b0}}, 1'b1};
      return (&v) ? v : (v + one);
   endfunction

   // Two-flop synchroniser that brings the asynchronous lock pin into clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         sync_meta <= pll_locked;
         locked_s  <= sync_meta;
      end
   end

   // State register and phase counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_PLL_RST;
         cnt   <= CNT_ZERO;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state and phase-counter logic. Every state entry clears the counter.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      retry_inc = 1'b0;
      lost_inc  = 1'b0;
      case (state)
         S_PLL_RST: begin
            if (soft_req) begin
               cnt_nx = CNT_ZERO;
            end else if (cnt == RST_LAST) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = CNT_ZERO;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         S_WAIT_LOCK: begin
            if (soft_req) begin
               state_nx = S_PLL_RST;
               cnt_nx   = CNT_ZERO;
            end else if (locked_s) begin
               state_nx = S_STABLE;
               cnt_nx   = CNT_ZERO;
            end else if (cnt == LOCK_LAST) begin
               state_nx  = S_PLL_RST;
               cnt_nx    = CNT_ZERO;
               retry_inc = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         S_STABLE: begin
            if (soft_req) begin
               state_nx = S_PLL_RST;
               cnt_nx   = CNT_ZERO;
            end else if (!locked_s) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = CNT_ZERO;
            end else if (cnt == STABLE_LAST) begin
               state_nx = S_RUN;
               cnt_nx   = CNT_ZERO;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               // Lock loss is counted even when a soft request arrives on the same cycle.
               state_nx = S_PLL_RST;
               cnt_nx   = CNT_ZERO;
               lost_inc = 1'b1;
            end else if (soft_req) begin
               state_nx = S_PLL_RST;
               cnt_nx   = CNT_ZERO;
            end else begin
               cnt_nx = CNT_ZERO;
            end
         end
         default: begin
            state_nx = S_PLL_RST;
            cnt_nx   = CNT_ZERO;
         end
      endcase
   end

   // Output decode from the next state, so the registered outputs move with the state.
   always_comb begin
      pll_rst_nx = 1'b1;
      sys_rst_nx = 1'b1;
      ready_nx   = 1'b0;
      case (state_nx)
         S_PLL_RST: begin
            pll_rst_nx = 1'b1;
            sys_rst_nx = 1'b1;
            ready_nx   = 1'b0;
         end
         S_WAIT_LOCK, S_STABLE: begin
            pll_rst_nx = 1'b0;
            sys_rst_nx = 1'b1;
            ready_nx   = 1'b0;
         end
         S_RUN: begin
            pll_rst_nx = 1'b0;
            sys_rst_nx = 1'b0;
            ready_nx   = 1'b1;
         end
         default: begin
            pll_rst_nx = 1'b1;
            sys_rst_nx = 1'b1;
            ready_nx   = 1'b0;
         end
      endcase
   end

   // Output registers and saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         retry_cnt <= {CNT_W{1'b0}};
         lost_cnt  <= {CNT_W{1'b0}};
      end else begin
         pll_rst   <= pll_rst_nx;
         sys_rst   <= sys_rst_nx;
         ready     <= ready_nx;
         retry_cnt <= retry_inc ? sat_inc(retry_cnt) : retry_cnt;
         lost_cnt  <= lost_inc  ? sat_inc(lost_cnt)  : lost_cnt;
      end
   end

endmodule
